// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared defaults and the command encoding for the program
//               counter and its return stack.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    localparam int PC_WIDTH = 16;
    localparam int PC_DEPTH = 8;

    // One command wins each cycle; the encoder in pc_unit picks it.
    typedef enum logic [2:0] {
        CMD_HOLD = 3'd0,
        CMD_INC  = 3'd1,
        CMD_LOAD = 3'd2,
        CMD_CALL = 3'd3,
        CMD_RET  = 3'd4
    } cmd_e;

endpackage
`default_nettype wire

// File: rtl/ret_stack.sv
`default_nettype none
// ============================================================================
// Module      : ret_stack
// Description : DEPTH x WIDTH LIFO holding return addresses. The caller only
//               pushes when not full and only pops when not empty.
// Revision    : 1.0 - initial release
// ============================================================================
module ret_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int C_AW  = $clog2(DEPTH);
    localparam int C_SPW = C_AW + 1;

    // sp counts entries (0..DEPTH), so it needs one bit more than an index.
    logic [C_SPW-1:0] r_sp;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW-1:0]  w_wr_idx;
    logic [C_AW-1:0]  w_rd_idx;

    assign w_wr_idx = r_sp[C_AW-1:0];
    assign w_rd_idx = r_sp[C_AW-1:0] - C_AW'(1);

    assign dout  = r_mem[w_rd_idx];
    assign full  = (r_sp == C_SPW'(DEPTH));
    assign empty = (r_sp == '0);

    // Stack pointer: reset discards all entries immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp <= '0;
        end else if (push) begin
            r_sp <= r_sp + C_SPW'(1);
        end else if (pop) begin
            r_sp <= r_sp - C_SPW'(1);
        end
    end

    // Storage is never observable after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[w_wr_idx] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Hack-style program counter with jump, increment and an
//               optional hardware return stack (call/ret).
//               Build option: define PC_STACK_EN to build the return stack;
//               without it call acts as load and ret acts as hold.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
    import pc_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = PC_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] out,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf
);

    cmd_e             w_cmd;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_pc_plus1;

    // Increment wraps silently at 2^WIDTH.
    assign w_pc_plus1 = r_pc + WIDTH'(1);
    assign out        = r_pc;

`ifdef PC_STACK_EN
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_top;
    logic             w_full;
    logic             w_empty;
    logic             r_ovf;
    logic             r_unf;

    // Priority encoder: ret > call > load > inc > hold.
    always_comb begin
        w_cmd = CMD_HOLD;
        if (ret) begin
            w_cmd = CMD_RET;
        end else if (call) begin
            w_cmd = CMD_CALL;
        end else if (load) begin
            w_cmd = CMD_LOAD;
        end else if (inc) begin
            w_cmd = CMD_INC;
        end
    end

    // An illegal call/ret is dropped entirely; only its sticky flag records it.
    assign w_push = (w_cmd == CMD_CALL) && !w_full;
    assign w_pop  = (w_cmd == CMD_RET)  && !w_empty;

    ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pc_plus1),
        .dout  (w_top),
        .full  (w_full),
        .empty (w_empty)
    );

    // Next program counter for the winning command.
    always_comb begin
        w_pc_next = r_pc;
        case (w_cmd)
            CMD_RET:  if (!w_empty) w_pc_next = w_top;
            CMD_CALL: if (!w_full)  w_pc_next = in;
            CMD_LOAD: w_pc_next = in;
            CMD_INC:  w_pc_next = w_pc_plus1;
            default:  w_pc_next = r_pc;
        endcase
    end

    // Sticky overflow/underflow flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if ((w_cmd == CMD_CALL) && w_full) begin
                r_ovf <= 1'b1;
            end
            if ((w_cmd == CMD_RET) && w_empty) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign full  = w_full;
    assign empty = w_empty;
    assign ovf   = r_ovf;
    assign unf   = r_unf;
`else
    // ret has no meaning without a stack.
    logic w_unused_ret;
    assign w_unused_ret = ret;

    // Priority encoder without a stack: load|call > inc > hold.
    always_comb begin
        w_cmd = CMD_HOLD;
        if (load || call) begin
            w_cmd = CMD_LOAD;
        end else if (inc) begin
            w_cmd = CMD_INC;
        end
    end

    // Next program counter for the winning command.
    always_comb begin
        w_pc_next = r_pc;
        case (w_cmd)
            CMD_LOAD: w_pc_next = in;
            CMD_INC:  w_pc_next = w_pc_plus1;
            default:  w_pc_next = r_pc;
        endcase
    end

    assign full  = 1'b0;
    assign empty = 1'b1;
    assign ovf   = 1'b0;
    assign unf   = 1'b0;
`endif

    // Program counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Self-checking bench for pc_unit. Vector table with expected
//               outputs, scoreboard queue, plus async-reset sequence.
//               Covers both PC_STACK_EN builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in;
    logic         load, inc, call, ret;
    logic [W-1:0] out;
    logic         full, empty, ovf, unf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] in;
        logic         load, inc, call, ret;
        logic [W-1:0] e_out;
        logic         e_full, e_empty, e_ovf, e_unf;
    } vec_t;

    typedef struct {
        int           idx;
        logic [W-1:0] e_out;
        logic         e_full, e_empty, e_ovf, e_unf;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    pc_unit #(.WIDTH(W), .DEPTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in),
        .load  (load),
        .inc   (inc),
        .call  (call),
        .ret   (ret),
        .out   (out),
        .full  (full),
        .empty (empty),
        .ovf   (ovf),
        .unf   (unf)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [W-1:0] i, logic l, logic n, logic c, logic r,
                                logic [W-1:0] eo, logic ef, logic ee, logic eov, logic eun);
        vec_t v;
        v.in = i; v.load = l; v.inc = n; v.call = c; v.ret = r;
        v.e_out = eo; v.e_full = ef; v.e_empty = ee; v.e_ovf = eov; v.e_unf = eun;
        return v;
    endfunction

    task automatic check_state(string name, logic [W-1:0] eo, logic ef, logic ee,
                               logic eov, logic eun);
        checks++;
        if (out !== eo || full !== ef || empty !== ee || ovf !== eov || unf !== eun) begin
            errors++;
            $display("FAIL %s: got out=%h full=%b empty=%b ovf=%b unf=%b, want out=%h full=%b empty=%b ovf=%b unf=%b",
                     name, out, full, empty, ovf, unf, eo, ef, ee, eov, eun);
        end
    endtask

    task automatic apply(vec_t v, int idx);
        exp_t e;
        @(negedge clk);
        in = v.in; load = v.load; inc = v.inc; call = v.call; ret = v.ret;
        e.idx = idx; e.e_out = v.e_out; e.e_full = v.e_full; e.e_empty = v.e_empty;
        e.e_ovf = v.e_ovf; e.e_unf = v.e_unf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_state($sformatf("vec%0d", e.idx), e.e_out, e.e_full, e.e_empty, e.e_ovf, e.e_unf);
    endtask

    initial begin
        rst = 1'b1; in = '0; load = 0; inc = 0; call = 0; ret = 0;
        repeat (2) @(negedge clk);
        check_state("reset", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;

        // in, load, inc, call, ret -> out, full, empty, ovf, unf
        for (int k = 1; k <= 5; k++) vecs.push_back(mk('0, 0, 1, 0, 0, W'(k), 0, 1, 0, 0));
        vecs.push_back(mk(16'h0100, 1, 1, 0, 0, 16'h0100, 0, 1, 0, 0));
        vecs.push_back(mk(16'h0000, 0, 1, 0, 0, 16'h0101, 0, 1, 0, 0));
`ifdef PC_STACK_EN
        vecs.push_back(mk(16'h0010, 1, 0, 0, 0, 16'h0010, 0, 1, 0, 0));
        vecs.push_back(mk(16'h0200, 0, 0, 1, 0, 16'h0200, 0, 0, 0, 0));
        vecs.push_back(mk(16'h0000, 0, 1, 0, 0, 16'h0201, 0, 0, 0, 0));
        vecs.push_back(mk(16'h0000, 0, 1, 0, 0, 16'h0202, 0, 0, 0, 0));
        vecs.push_back(mk(16'h0000, 0, 0, 0, 1, 16'h0011, 0, 1, 0, 0));
        vecs.push_back(mk(16'h0000, 0, 0, 0, 1, 16'h0011, 0, 1, 0, 1));
        vecs.push_back(mk(16'h0000, 0, 1, 0, 0, 16'h0012, 0, 1, 0, 1));
        vecs.push_back(mk(16'h0400, 0, 0, 1, 0, 16'h0400, 0, 0, 0, 1));
        vecs.push_back(mk(16'h0500, 0, 0, 1, 0, 16'h0500, 0, 0, 0, 1));
        vecs.push_back(mk(16'h0600, 0, 0, 1, 1, 16'h0401, 0, 0, 0, 1));
        vecs.push_back(mk(16'h0000, 0, 0, 0, 1, 16'h0013, 0, 1, 0, 1));
        vecs.push_back(mk(16'hFFFF, 1, 0, 0, 0, 16'hFFFF, 0, 1, 0, 1));
        vecs.push_back(mk(16'h0000, 0, 1, 0, 0, 16'h0000, 0, 1, 0, 1));
        // Fill the stack: call k jumps to 0x1000+16k and pushes the prior out+1.
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(16'h1000 + W'(16 * k), 0, 0, 1, 0, 16'h1000 + W'(16 * k),
                              (k == 7), 0, 0, 1));
        vecs.push_back(mk(16'h0300, 0, 0, 1, 0, 16'h1070, 1, 0, 1, 1));
        // Unwind: entries come back last-in first-out.
        for (int j = 0; j < 8; j++)
            vecs.push_back(mk('0, 0, 0, 0, 1,
                              (j == 7) ? 16'h0001 : 16'h1001 + W'(16 * (6 - j)),
                              0, (j == 7), 1, 1));
`else
        vecs.push_back(mk(16'h0040, 0, 0, 1, 0, 16'h0040, 0, 1, 0, 0));
        vecs.push_back(mk(16'h0000, 0, 0, 0, 1, 16'h0040, 0, 1, 0, 0));
        vecs.push_back(mk(16'h0000, 0, 1, 0, 1, 16'h0041, 0, 1, 0, 0));
        vecs.push_back(mk(16'h0080, 0, 1, 1, 0, 16'h0080, 0, 1, 0, 0));
        vecs.push_back(mk(16'hFFFF, 1, 0, 0, 0, 16'hFFFF, 0, 1, 0, 0));
        vecs.push_back(mk(16'h0000, 0, 1, 0, 0, 16'h0000, 0, 1, 0, 0));
        vecs.push_back(mk(16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0));
        vecs.push_back(mk(16'h1234, 1, 0, 0, 0, 16'h1234, 0, 1, 0, 0));
`endif

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Asynchronous reset mid-cycle must clear state before the next edge.
        @(negedge clk);
        in = '0; load = 0; inc = 0; call = 0; ret = 0;
        #2 rst = 1'b1;
        #1 check_state("async_rst", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        apply(mk('0, 0, 1, 0, 0, 16'h0001, 0, 1, 0, 0), 999);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Hack-style program counter with a small hardware return stack; sits directly downstream of the jump-condition gating.
- The upstream And gate produces the jump-enable that drives `load`; this block consumes it and produces the instruction address.
- Supports reset, load (jump), increment, call (push return address and jump) and return (pop).

Parameters:
- WIDTH, 16, address/data width in bits.
- DEPTH, 8, return-stack entries (power of two, >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in  input  WIDTH  jump/call target address.
- load  input  1  jump enable (from And-gate jump logic).
- inc  input  1  increment enable.
- call  input  1  push out+1, then jump to in.
- ret  input  1  pop top of stack into out.
- out  output  WIDTH  current program counter.
- full  output  1  stack holds DEPTH entries.
- empty  output  1  stack holds 0 entries.
- ovf  output  1  sticky: call attempted while full.
- unf  output  1  sticky: ret attempted while empty.

Behaviour:
- Reset is asynchronous and active-high; there is one clock, clk.
- Reset values: out=0, stack pointer=0, empty=1, full=0, ovf=0, unf=0.
- Stack contents are don't-care after reset and are never observable.
- All updates happen on the rising edge of clk; out changes 1 cycle after the command is sampled.
- Priority per cycle: ret > call > load > inc > hold.
- ret, stack not empty: out <= top; sp <= sp-1.
- ret, stack empty: out holds; unf <= 1; sp unchanged.
- call, stack not full: mem[sp] <= out+1 (mod 2^WIDTH); sp <= sp+1; out <= in.
- call, stack full: the whole call is ignored, so out holds (no jump) and sp is unchanged; ovf <= 1.
- load: out <= in.
- inc: out <= out+1; wraps from 2^WIDTH-1 to 0 silently.
- No command asserted: out holds.
- Simultaneous commands: only the highest-priority command takes effect. The others are dropped, with no side effects and no flag changes.
- Because ret wins over call, ret and call together never push.
- full/empty are combinational from sp: empty = (sp==0), full = (sp==DEPTH). sp is $clog2(DEPTH)+1 bits wide.
- ovf/unf are cleared only by rst.
- rst asserted mid-sequence (e.g. between a call and its ret) discards all stack state immediately, without waiting for a clock edge.
- in is sampled only on the edge where load or call takes effect.

Optional Feature:
- Macro: PC_STACK_EN.
- Defined: the return stack, call/ret semantics, and full/empty/ovf/unf are as above.
- Undefined: no stack storage is built.
  - call behaves exactly as load.
  - ret behaves as hold.
  - full=0, empty=1, ovf=0, unf=0 constantly.
  - Priority becomes load|call > inc > hold.

Decomposition:
- Package pc_pkg:
  - PC_WIDTH default constant.
  - PC_DEPTH default constant.
  - Command enum (CMD_HOLD, CMD_INC, CMD_LOAD, CMD_CALL, CMD_RET) produced by the priority encoder.
- One sub-module, ret_stack:
  - LIFO of DEPTH x WIDTH.
  - push/pop/din/dout/full/empty.
  - Push or pop only when legal; the caller guarantees this.
  - Instantiated only under PC_STACK_EN.
- Priority encoding and flag logic live in pc_unit.

Test Plan:
- Reset/increment: rst pulse, then inc=1 for 5 cycles -> out=0,1,2,3,4,5. Assert rst asynchronously mid-cycle -> out=0 before the next edge.
- Jump priority: out=5; load=1, inc=1, in=0x0100 -> out=0x0100 next cycle. Next cycle load=0, inc=1 -> out=0x0101.
- Call/return: out=0x0010; call with in=0x0200 -> out=0x0200, empty=0. Two inc -> 0x0202. ret -> out=0x0011, empty=1.
- Stack overflow: DEPTH=8; 8 calls -> full=1. 9th call with in=0x0300 -> out unchanged, ovf=1, sp still 8. Then 8 rets return the addresses in reverse order.
- Underflow and wrap:
  - ret on empty -> out holds, unf=1; unf stays set until rst.
  - out=0xFFFF, inc -> out=0x0000.
  - ret+call together with stack non-empty -> pop only, sp decrements by 1.
- Feature off (PC_STACK_EN undefined): call with in=0x0040 -> out=0x0040. ret -> out holds. Flags read full=0, empty=1, ovf=0, unf=0.
